instr_fetch_buffer: RTL and testbench

Instruction fetch buffer on the consuming side of the program counter. It accepts fetch addresses from the PC sequencer and issues in-order read requests to instruction memory. It collects the in-order responses into a DEPTH-entry queue and delivers (pc, instruction) pairs to decode with valid/ready flow control. A flush drops all queued and in-flight fetches after a jump or branch redirect.

---
 rtl/ifb_pkg.sv | 28 ++
 rtl/ifb_slot_queue.sv | 99 +++++++++
 rtl/instr_fetch_buffer.sv | 102 ++++++++++
 tb/tb_instr_fetch_buffer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifb_pkg.sv
// Shared types and helpers for the instruction fetch buffer.
package ifb_pkg;

  // Datapath width the slot storage is built for.
  localparam int IFB_WIDTH     = 32;
  // Smallest legal queue depth.
  localparam int IFB_DEPTH_MIN = 2;

  // One queue entry: fetch address, returned word, ready-to-deliver flag and
  // the alignment-fault marker.
  typedef struct packed {
    logic [IFB_WIDTH-1:0] pc;
    logic [IFB_WIDTH-1:0] data;
    logic                 filled;
    logic                 misaligned;
  } ifb_slot_t;

  // Pointer width for a queue of the given depth; counts use one more bit.
  function automatic int ifb_ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Depth must be a power of two so the pointers wrap for free.
  function automatic bit ifb_depth_ok(input int depth);
    return (depth >= IFB_DEPTH_MIN) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/ifb_slot_queue.sv
// Slot storage with head/tail/fill pointers for the fetch buffer.
// IFB_ALIGN_CHECK_EN: slots may be allocated pre-filled (alignment fault);
// the fill pointer then skips them to find the next slot owed a response.
module ifb_slot_queue
  import ifb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = ifb_ptr_w(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_flush,
  input  logic                 i_alloc,
  input  logic [IFB_WIDTH-1:0] i_alloc_pc,
`ifdef IFB_ALIGN_CHECK_EN
  input  logic                 i_alloc_mis,
`endif
  input  logic                 i_rsp_we,
  input  logic [IFB_WIDTH-1:0] i_rsp_data,
  input  logic                 i_deliver,
  output ifb_slot_t            o_head
);

  ifb_slot_t     r_slot [DEPTH];
  logic [PW-1:0] r_head, r_tail, r_fill;
  logic [PW-1:0] w_fill;
  logic          w_mis;

`ifdef IFB_ALIGN_CHECK_EN
  logic [DEPTH-1:0] r_alloc;
  logic [PW-1:0]    w_idx;
  logic             w_found;

  assign w_mis = i_alloc_mis;

  // Track which slots are allocated so pre-filled ones can be skipped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_alloc <= '0;
    else if (i_flush) r_alloc <= '0;
    else begin
      if (i_alloc)   r_alloc[r_tail] <= 1'b1;
      if (i_deliver) r_alloc[r_head] <= 1'b0;
    end
  end

  // First allocated-but-unfilled slot at or after the fill pointer.
  always_comb begin
    w_fill  = r_fill;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_fill + PW'(k);
      if (!w_found && r_alloc[w_idx] && !r_slot[w_idx].filled) begin
        w_fill  = w_idx;
        w_found = 1'b1;
      end
    end
  end
`else
  assign w_mis  = 1'b0;
  assign w_fill = r_fill;
`endif

  // Allocate at tail, fill at fill, retire at head; flush empties the queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_fill <= '0;
      for (int i = 0; i < DEPTH; i++) r_slot[i] <= '0;
    end else if (i_flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_fill <= '0;
      for (int i = 0; i < DEPTH; i++) r_slot[i].filled <= 1'b0;
    end else begin
      if (i_alloc) begin
        r_slot[r_tail].pc         <= i_alloc_pc;
        r_slot[r_tail].data       <= '0;
        r_slot[r_tail].filled     <= w_mis;
        r_slot[r_tail].misaligned <= w_mis;
        r_tail                    <= r_tail + 1'b1;
      end
      if (i_rsp_we) begin
        r_slot[w_fill].data   <= i_rsp_data;
        r_slot[w_fill].filled <= 1'b1;
        r_fill                <= w_fill + 1'b1;
      end
      // Clearing filled on retire keeps a wrapped-around empty head invalid.
      if (i_deliver) begin
        r_slot[r_head].filled <= 1'b0;
        r_head                <= r_head + 1'b1;
      end
    end
  end

  assign o_head = r_slot[r_head];

endmodule

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: issues in-order fetches, queues responses,
// delivers (pc, instr) to decode; flush discards queued and in-flight work.
// IFB_ALIGN_CHECK_EN: misaligned pcs bypass memory and are delivered with
// instr_misaligned set and instr = 0.
module instr_fetch_buffer
  import ifb_pkg::*;
#(
  parameter int WIDTH = IFB_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pc,
  input  logic             pc_valid,
  output logic             pc_ready,
  input  logic             flush,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [WIDTH-1:0] mem_req_addr,
  input  logic             mem_rsp_valid,
  input  logic [WIDTH-1:0] mem_rsp_data,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr,
`ifdef IFB_ALIGN_CHECK_EN
  output logic             instr_misaligned,
`endif
  output logic [WIDTH-1:0] instr_pc
);

  localparam int PW = ifb_ptr_w(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = PW + 2;

  if (!ifb_depth_ok(DEPTH) || WIDTH != IFB_WIDTH || (WIDTH % 8) != 0) begin : g_bad_cfg
    $error("instr_fetch_buffer: unsupported WIDTH/DEPTH");
  end

  logic [CW-1:0] r_used, r_outst, r_discard;
  logic          w_credit, w_mis, w_hs, w_mem_hs, w_drop, w_rsp_acc, w_deliver;
  ifb_slot_t     w_head;

  // Stale responses still owed to memory hold back credit so the total
  // in-flight count never exceeds DEPTH.
  assign w_credit = (SW'(r_used) + SW'(r_discard)) < SW'(DEPTH);

`ifdef IFB_ALIGN_CHECK_EN
  assign w_mis    = |(pc & WIDTH'((WIDTH / 8) - 1));
  assign pc_ready = reset_n && w_credit && !flush && (mem_req_ready || w_mis);
  assign instr_misaligned = w_head.misaligned;
`else
  assign w_mis    = 1'b0;
  assign pc_ready = reset_n && w_credit && !flush && mem_req_ready;
`endif

  assign mem_req_valid = reset_n && pc_valid && w_credit && !flush && !w_mis;
  assign mem_req_addr  = pc;
  assign w_hs          = pc_valid && pc_ready;
  assign w_mem_hs      = mem_req_valid && mem_req_ready;
  assign w_drop        = mem_rsp_valid && (r_discard != '0);
  assign w_rsp_acc     = mem_rsp_valid && (r_discard == '0);
  assign w_deliver     = instr_valid && instr_ready && !flush;

  // Occupancy, outstanding-request and discard bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_used    <= '0;
      r_outst   <= '0;
      r_discard <= '0;
    end else if (flush) begin
      // Everything still in flight at memory becomes a discard; a response
      // landing this cycle is charged against the pre-flush total.
      r_used    <= '0;
      r_outst   <= '0;
      r_discard <= r_discard + r_outst - CW'(mem_rsp_valid);
    end else begin
      r_used    <= r_used + CW'(w_hs) - CW'(w_deliver);
      r_outst   <= r_outst + CW'(w_mem_hs) - CW'(w_rsp_acc);
      r_discard <= r_discard - CW'(w_drop);
    end
  end

  ifb_slot_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_flush     (flush),
    .i_alloc     (w_hs),
    .i_alloc_pc  (pc),
`ifdef IFB_ALIGN_CHECK_EN
    .i_alloc_mis (w_mis),
`endif
    .i_rsp_we    (w_rsp_acc && !flush),
    .i_rsp_data  (mem_rsp_data),
    .i_deliver   (w_deliver),
    .o_head      (w_head)
  );

  assign instr_valid = w_head.filled;
  assign instr       = w_head.data;
  assign instr_pc    = w_head.pc;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer (WIDTH=32, DEPTH=4).
// Memory responses are driven by hand with 1-cycle latency; words are
// 0xCAFE_0000 | addr for live fetches and 0xDEAD_xxxx for stale ones.
module tb_instr_fetch_buffer;

  logic        clk, reset_n;
  logic [31:0] pc;
  logic        pc_valid, pc_ready, flush;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
`ifdef IFB_ALIGN_CHECK_EN
  logic        instr_misaligned;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  instr_fetch_buffer #(.WIDTH(32), .DEPTH(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pc            (pc),
    .pc_valid      (pc_valid),
    .pc_ready      (pc_ready),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
`ifdef IFB_ALIGN_CHECK_EN
    .instr_misaligned (instr_misaligned),
`endif
    .instr_pc      (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drv(input logic pv, input logic [31:0] a, input logic mrr,
                     input logic rv, input logic [31:0] rd, input logic fl,
                     input logic ir);
    pc_valid      = pv;
    pc            = a;
    mem_req_ready = mrr;
    mem_rsp_valid = rv;
    mem_rsp_data  = rd;
    flush         = fl;
    instr_ready   = ir;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, with a pc offered to show requests are gated.
    reset_n = 1'b0;
    drv(1, 32'h0, 1, 0, 0, 0, 0);
    #1;
    chk("rst_ivalid", instr_valid, 0);
    chk("rst_reqv",   mem_req_valid, 0);
    chk("rst_pcrdy",  pc_ready, 0);
    chk("rst_instr",  instr, 0);
    chk("rst_ipc",    instr_pc, 0);
    drv(0, 0, 0, 0, 0, 0, 0);
    cyc(); cyc();
    @(negedge clk) reset_n = 1'b1;
    cyc();

    // Back-to-back fetches, 1-cycle memory latency, decode always ready.
    drv(1, 32'h0, 1, 0, 0, 0, 1);
    #1;
    chk("b2b_reqv", mem_req_valid, 1);
    chk("b2b_addr", mem_req_addr, 32'h0);
    cyc();
    drv(1, 32'h4, 1, 1, 32'hCAFE0000, 0, 1);
    #1; chk("b2b_lat", instr_valid, 0);
    cyc();
    drv(1, 32'h8, 1, 1, 32'hCAFE0004, 0, 1);
    #1;
    chk("b2b_v0", instr_valid, 1);
    chk("b2b_pc0", instr_pc, 32'h0);
    chk("b2b_d0", instr, 32'hCAFE0000);
    cyc();
    drv(0, 0, 1, 1, 32'hCAFE0008, 0, 1);
    #1;
    chk("b2b_pc4", instr_pc, 32'h4);
    chk("b2b_d4", instr, 32'hCAFE0004);
    cyc();
    drv(0, 0, 1, 0, 0, 0, 1);
    #1;
    chk("b2b_v8", instr_valid, 1);
    chk("b2b_pc8", instr_pc, 32'h8);
    chk("b2b_d8", instr, 32'hCAFE0008);
    cyc();
    #1; chk("b2b_empty", instr_valid, 0);

    // Backpressure: four fetches fill the queue, the fifth is refused.
    drv(1, 32'h10, 1, 0, 0, 0, 0);            cyc();
    drv(1, 32'h14, 1, 1, 32'hCAFE0010, 0, 0); cyc();
    drv(1, 32'h18, 1, 1, 32'hCAFE0014, 0, 0); cyc();
    drv(1, 32'h1C, 1, 1, 32'hCAFE0018, 0, 0); cyc();
    drv(1, 32'h20, 1, 1, 32'hCAFE001C, 0, 0);
    #1;
    chk("bp_full_rdy", pc_ready, 0);
    chk("bp_full_req", mem_req_valid, 0);
    chk("bp_head", instr_pc, 32'h10);
    cyc();
    drv(1, 32'h20, 1, 0, 0, 0, 1);
    #1; chk("bp_still_full", pc_ready, 0);
    cyc();
    #1;
    chk("bp_freed", pc_ready, 1);
    chk("bp_pc14", instr_pc, 32'h14);
    cyc();
    drv(0, 0, 1, 1, 32'hCAFE0020, 0, 1);
    #1; chk("bp_pc18", instr_pc, 32'h18);
    cyc();
    drv(0, 0, 1, 0, 0, 0, 1);
    #1; chk("bp_pc1c", instr_pc, 32'h1C);
    cyc();
    #1;
    chk("bp_pc20", instr_pc, 32'h20);
    chk("bp_d20", instr, 32'hCAFE0020);
    cyc();
    #1; chk("bp_empty", instr_valid, 0);

    // Flush with two requests in flight; their late responses are dropped.
    drv(1, 32'h40, 1, 0, 0, 0, 0); cyc();
    drv(1, 32'h44, 1, 0, 0, 0, 0); cyc();
    drv(0, 0, 1, 0, 0, 1, 0);
    #1; chk("fl_pcrdy", pc_ready, 0);
    cyc();
    drv(1, 32'h100, 1, 1, 32'hDEAD0040, 0, 0);
    #1;
    chk("fl_new_req", mem_req_valid, 1);
    chk("fl_stale0", instr_valid, 0);
    cyc();
    drv(0, 0, 1, 1, 32'hDEAD0044, 0, 0);
    #1; chk("fl_stale1", instr_valid, 0);
    cyc();
    drv(0, 0, 1, 1, 32'hCAFE0100, 0, 0);
    #1; chk("fl_wait", instr_valid, 0);
    cyc();
    drv(0, 0, 1, 0, 0, 0, 1);
    #1;
    chk("fl_v", instr_valid, 1);
    chk("fl_pc", instr_pc, 32'h100);
    chk("fl_d", instr, 32'hCAFE0100);
    cyc();
    #1; chk("fl_empty", instr_valid, 0);

    // Flush together with pc_valid and instr_ready.
    drv(1, 32'h200, 1, 0, 0, 0, 0);            cyc();
    drv(0, 0, 1, 1, 32'hCAFE0200, 0, 0);       cyc();
    drv(1, 32'h204, 1, 0, 0, 1, 1);
    #1;
    chk("flc_reqv", mem_req_valid, 0);
    chk("flc_pcrdy", pc_ready, 0);
    cyc();
    drv(1, 32'h300, 1, 0, 0, 0, 0);
    #1;
    chk("flc_nodeliv", instr_valid, 0);
    chk("flc_credit", pc_ready, 1);
    cyc();
    drv(0, 0, 1, 1, 32'hCAFE0300, 0, 0);       cyc();
    drv(0, 0, 1, 0, 0, 0, 1);
    #1;
    chk("flc_pc", instr_pc, 32'h300);
    chk("flc_d", instr, 32'hCAFE0300);
    cyc();

    // Reset mid-stream with three filled slots.
    drv(1, 32'h400, 1, 0, 0, 0, 0);            cyc();
    drv(1, 32'h404, 1, 1, 32'hCAFE0400, 0, 0); cyc();
    drv(1, 32'h408, 1, 1, 32'hCAFE0404, 0, 0); cyc();
    drv(0, 0, 1, 1, 32'hCAFE0408, 0, 0);       cyc();
    drv(1, 32'h40C, 1, 0, 0, 0, 0);
    #1;
    chk("mrst_pre_v", instr_valid, 1);
    chk("mrst_pre_pc", instr_pc, 32'h400);
    #1; reset_n = 1'b0;
    #1;
    chk("mrst_v", instr_valid, 0);
    chk("mrst_reqv", mem_req_valid, 0);
    chk("mrst_pc", instr_pc, 0);
    drv(0, 0, 0, 0, 0, 0, 0);
    cyc();
    @(negedge clk) reset_n = 1'b1;
    cyc();
    drv(1, 32'h0, 1, 0, 0, 0, 0);              cyc();
    drv(0, 0, 1, 1, 32'hCAFE0000, 0, 0);       cyc();
    drv(0, 0, 1, 0, 0, 0, 1);
    #1;
    chk("mrst_post_v", instr_valid, 1);
    chk("mrst_post_pc", instr_pc, 32'h0);
    chk("mrst_post_d", instr, 32'hCAFE0000);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0);

`ifdef IFB_ALIGN_CHECK_EN
    // Misaligned pc: no memory request, delivered in order with data 0.
    drv(1, 32'h500, 1, 0, 0, 0, 0);            cyc();
    drv(1, 32'h502, 0, 1, 32'hCAFE0500, 0, 0);
    #1;
    chk("al_noreq", mem_req_valid, 0);
    chk("al_accept", pc_ready, 1);
    cyc();
    drv(1, 32'h504, 1, 0, 0, 0, 0);            cyc();
    drv(0, 0, 1, 1, 32'hCAFE0504, 0, 0);       cyc();
    drv(0, 0, 1, 0, 0, 0, 1);
    #1;
    chk("al_pc0", instr_pc, 32'h500);
    chk("al_d0", instr, 32'hCAFE0500);
    chk("al_m0", instr_misaligned, 0);
    cyc();
    #1;
    chk("al_pc1", instr_pc, 32'h502);
    chk("al_d1", instr, 32'h0);
    chk("al_m1", instr_misaligned, 1);
    cyc();
    #1;
    chk("al_pc2", instr_pc, 32'h504);
    chk("al_d2", instr, 32'hCAFE0504);
    chk("al_m2", instr_misaligned, 0);
    cyc();
    #1; chk("al_empty", instr_valid, 0);
    drv(0, 0, 0, 0, 0, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
